// File: rtl/data_ram.sv
// Byte-addressed synchronous data memory with registered load port,
// byte-lane stores, narrow-load extension, fault detection and init sweep.
module data_ram #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 64,
  parameter bit INIT_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] out,
  output logic              ready,
  output logic              fault
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IDX = $clog2(DEPTH);
  localparam int HI  = OFF + IDX;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [IDX-1:0]    cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [OFF-1:0]    off;
  logic [IDX-1:0]    idx;
  logic              upper_ok;
  logic              legal;
  logic              aligned;
  logic              req;
  logic              bad;
  logic              do_wr;
  logic              do_rd;
  logic [DATA_W-1:0] fill;
  logic [NB-1:0]     wmask;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] rdata;
  logic              msb;
  int                nb;
  int                offi;
  int                bits;

  assign off      = address[OFF-1:0];
  assign idx      = address[HI-1:OFF];
  assign upper_ok = (address >> HI) == '0;
  assign fill     = INIT_MODE ? DATA_W'(cnt) * DATA_W'(100) : '0;

  always_comb begin
    nb      = 1 << size;
    offi    = int'(off);
    bits    = nb * 8;
    legal   = nb <= NB;
    aligned = (offi % nb) == 0;
    req     = (state == RUN) && (read_en || write_en);
    bad     = req && !(legal && aligned && upper_ok);
    do_wr   = req && !bad && write_en;
    do_rd   = req && !bad && !write_en;
  end

  // Store data is pre-shifted into its lanes; the mask picks the lanes touched.
  always_comb begin
    wmask = '0;
    wdata = data_in << (8 * offi);
    for (int b = 0; b < NB; b++) begin
      if (b >= offi && b < offi + nb) wmask[b] = 1'b1;
    end
  end

  always_comb begin
    raw   = mem[idx] >> (8 * offi);
    rdata = raw;
    msb   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == bits - 1) msb = raw[i];
    end
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= bits) rdata[i] = sign_ext & msb;
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= fill;
    end else if (do_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
      out   <= '0;
      ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          fault <= bad;
          if (bad)        out <= '0;
          else if (do_rd) out <= rdata;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
